// File: rtl/game_button_conditioner.sv
// game_button_conditioner
// Input stage for the 8x8 LED dodge game. Raw left/right/start buttons are
// synchronised and debounced. Left/right presses become move requests that are
// held until the next mv_tick. Start becomes a single-cycle pulse.
// Optional feature: define REPEAT_EN to enable auto-repeat of held left/right
// buttons.
//
// Handshake: a move request is set by a press (or repeat) event and is consumed
// by the first mv_tick cycle strictly after the event. An event in the same
// cycle as mv_tick survives that tick. Left and right requests consumed by the
// same tick cancel each other.
module game_button_conditioner #(
   parameter int DB_CYCLES = 50000,
   parameter int DB_W      = 16,
   parameter int RPT_DELAY = 25000000,
   parameter int RPT_RATE  = 3500000,
   parameter int RPT_W     = 26
) (
   input  logic       CLK,
   input  logic       clear,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_start,
   input  logic       mv_tick,
   output logic       move_left,
   output logic       move_right,
   output logic       start_pulse,
   output logic [2:0] btn_level
);

   // Reject parameter sets whose counters cannot hold their terminal values.
   if ((DB_W < 1) || (DB_CYCLES < 1) || (DB_CYCLES >= (1 << DB_W)) ||
       (RPT_RATE < 1) || (RPT_RATE > RPT_DELAY) || (RPT_DELAY > (1 << RPT_W))) begin : g_bad_cfg
      $error("game_button_conditioner: inconsistent counter parameters");
   end

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   // Channel index: 0 = left, 1 = right, 2 = start.
   logic [2:0]      s1;
   logic [2:0]      s2;
   logic [DB_W-1:0] db_cnt [3];
   logic [2:0]      level;
   logic [2:0]      level_d;
   logic [2:0]      press;
   logic [1:0]      rpt_hit;
   logic            pend_l;
   logic            pend_r;
   logic            set_l;
   logic            set_r;

   // Two-flop synchroniser for all three raw buttons.
   always_ff @(posedge CLK or negedge clear) begin
      if (!clear) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {btn_start, btn_right, btn_left};
         s2 <= s1;
      end
   end

   // Debounce: accept s2 once it has differed from the level for DB_CYCLES cycles.
   always_ff @(posedge CLK or negedge clear) begin
      if (!clear) begin
         level <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               level[i]  <= s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Delayed copy of the debounced levels for rising-edge (press) detection.
   always_ff @(posedge CLK or negedge clear) begin
      if (!clear) level_d <= '0;
      else        level_d <= level;
   end

   assign press     = level & ~level_d;
   assign btn_level = level;

`ifdef REPEAT_EN
   localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(RPT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RPT_DELAY - RPT_RATE);

   logic [RPT_W-1:0] hold_cnt [2];

   // A repeat fires in the cycle where a held button's counter hits its terminal value.
   always_comb begin
      rpt_hit = 2'b00;
      for (int i = 0; i < 2; i++) rpt_hit[i] = level[i] && (hold_cnt[i] == RPT_LAST);
   end

   // Hold counters: run while the level is high, reload after each repeat.
   always_ff @(posedge CLK or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < 2; i++) hold_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!level[i])       hold_cnt[i] <= '0;
            else if (rpt_hit[i]) hold_cnt[i] <= RPT_RELOAD;
            else                 hold_cnt[i] <= hold_cnt[i] + 1'b1;
         end
      end
   end
`else
   assign rpt_hit = 2'b00;
`endif

   assign set_l = press[0] | rpt_hit[0];
   assign set_r = press[1] | rpt_hit[1];

   // Pending requests: a tick consumes what was pending before it; same-cycle sets survive.
   always_ff @(posedge CLK or negedge clear) begin
      if (!clear) begin
         pend_l      <= 1'b0;
         pend_r      <= 1'b0;
         move_left   <= 1'b0;
         move_right  <= 1'b0;
         start_pulse <= 1'b0;
      end else begin
         pend_l      <= (pend_l & ~mv_tick) | set_l;
         pend_r      <= (pend_r & ~mv_tick) | set_r;
         move_left   <= mv_tick & pend_l & ~pend_r;
         move_right  <= mv_tick & pend_r & ~pend_l;
         start_pulse <= press[2];
      end
   end

endmodule

// File: tb/tb_game_button_conditioner.sv
// Testbench for game_button_conditioner (DB_CYCLES=4, RPT_DELAY=20, RPT_RATE=8).
module tb_game_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RR = 8;
`ifdef REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       clear = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_start = 1'b0;
   logic       mv_tick = 1'b0;
   logic       move_left;
   logic       move_right;
   logic       start_pulse;
   logic [2:0] btn_level;

   // clock
   always #5 CLK = ~CLK;

   game_button_conditioner #(
      .DB_CYCLES(DB), .DB_W(3), .RPT_DELAY(RD), .RPT_RATE(RR), .RPT_W(5)
   ) dut (
      .CLK(CLK), .clear(clear), .btn_left(btn_left), .btn_right(btn_right),
      .btn_start(btn_start), .mv_tick(mv_tick), .move_left(move_left),
      .move_right(move_right), .start_pulse(start_pulse), .btn_level(btn_level)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference model: raw samples since reset, accepted levels, requests, hold times.
   logic [2:0] raw_q[$];
   logic [2:0] m_lvl, m_lvl_d;
   logic       m_pl, m_pr, m_ml, m_mr, m_sp;
   int         m_held[2];

   task automatic model_reset();
      raw_q = {};
      repeat (DB + 2) raw_q.push_back(3'b000);
      m_lvl = 0; m_lvl_d = 0;
      m_pl = 0; m_pr = 0; m_ml = 0; m_mr = 0; m_sp = 0;
      m_held[0] = 0; m_held[1] = 0;
   endtask

   // One clock edge: a level is accepted once the synchronised input (raw delayed
   // by two edges) has shown the opposite value for DB consecutive samples.
   task automatic model_edge(input logic [2:0] raw, input logic tick);
      logic [2:0] ev;
      logic [1:0] rpt;
      int n;
      bit stable;
      ev = m_lvl & ~m_lvl_d;
      for (int c = 0; c < 2; c++)
         rpt[c] = REP && m_lvl[c] && (m_held[c] >= RD - 1) && (((m_held[c] - (RD - 1)) % RR) == 0);
      m_ml = tick & m_pl & ~m_pr;
      m_mr = tick & m_pr & ~m_pl;
      m_pl = (m_pl & ~tick) | ev[0] | rpt[0];
      m_pr = (m_pr & ~tick) | ev[1] | rpt[1];
      m_sp = ev[2];
      for (int c = 0; c < 2; c++) m_held[c] = m_lvl[c] ? m_held[c] + 1 : 0;
      m_lvl_d = m_lvl;
      raw_q.push_back(raw);
      void'(raw_q.pop_front());
      n = raw_q.size();
      for (int c = 0; c < 3; c++) begin
         stable = 1'b1;
         for (int j = 0; j < DB; j++)
            if (raw_q[n - 3 - j][c] == m_lvl[c]) stable = 1'b0;
         if (stable) m_lvl[c] = ~m_lvl[c];
      end
   endtask

   // Driver: apply inputs at negedge, advance one edge, compare against the model.
   task automatic step(input logic [2:0] btn, input logic tick, input logic clr);
      @(negedge CLK);
      {btn_start, btn_right, btn_left} = btn;
      mv_tick = tick;
      clear = clr;
      @(posedge CLK);
      if (!clr) model_reset();
      else model_edge(btn, tick);
      #1;
      check("model.btn_level", btn_level, m_lvl);
      check("model.move_left", {2'b0, move_left}, {2'b0, m_ml});
      check("model.move_right", {2'b0, move_right}, {2'b0, m_mr});
      check("model.start_pulse", {2'b0, start_pulse}, {2'b0, m_sp});
      check("move_exclusive", {2'b0, move_left & move_right}, 3'b000);
   endtask

   typedef struct {
      logic [2:0] btn;
      logic       tick;
      int         n;
      logic [2:0] lvl;
      logic       ml;
      logic       mr;
      logic       sp;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [2:0] b;
      logic exp_mr;

      // directed vector table (each group starts and ends idle)
      tbl.push_back('{3'b001, 1'b0, 5, 3'b000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b0, 1, 3'b001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b0, 2, 3'b001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b1, 1, 3'b001, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b0, 1, 3'b001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b1, 1, 3'b001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b000, 1'b0, 5, 3'b001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b000, 1'b0, 1, 3'b000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b011, 1'b0, 6, 3'b011, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b011, 1'b0, 2, 3'b011, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b011, 1'b1, 1, 3'b011, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b011, 1'b0, 1, 3'b011, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b000, 1'b0, 6, 3'b000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b010, 1'b0, 6, 3'b010, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b010, 1'b0, 2, 3'b010, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b010, 1'b1, 1, 3'b010, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{3'b010, 1'b0, 1, 3'b010, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b000, 1'b0, 6, 3'b000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b000, 1'b1, 1, 3'b000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b000, 1'b0, 1, 3'b000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b0, 6, 3'b001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b1, 1, 3'b001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b0, 1, 3'b001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b001, 1'b1, 1, 3'b001, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{3'b000, 1'b0, 6, 3'b000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b100, 1'b0, 6, 3'b100, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b100, 1'b0, 1, 3'b100, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{3'b100, 1'b0, 1, 3'b100, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{3'b000, 1'b0, 6, 3'b000, 1'b0, 1'b0, 1'b0});

      // reset
      model_reset();
      repeat (3) step(3'b000, 1'b0, 1'b0);
      check("reset.btn_level", btn_level, 3'b000);
      check("reset.pulses", {move_left, move_right, start_pulse}, 3'b000);
      repeat (6) step(3'b000, 1'b0, 1'b1);

      // table-driven directed vectors
      for (int i = 0; i < tbl.size(); i++) begin
         repeat (tbl[i].n) step(tbl[i].btn, tbl[i].tick, 1'b1);
         check($sformatf("tbl[%0d].btn_level", i), btn_level, tbl[i].lvl);
         check($sformatf("tbl[%0d].pulses", i), {move_left, move_right, start_pulse},
               {tbl[i].ml, tbl[i].mr, tbl[i].sp});
      end

      // glitch train shorter than the debounce window
      for (int i = 0; i < 30; i++) begin
         step((((i / 2) % 2) != 0) ? 3'b001 : 3'b000, (i % 5) == 0, 1'b1);
         check("glitch.level_left", {2'b0, btn_level[0]}, 3'b000);
         check("glitch.move_left", {2'b0, move_left}, 3'b000);
      end
      repeat (6) step(3'b000, 1'b0, 1'b1);
      step(3'b000, 1'b1, 1'b1);
      step(3'b000, 1'b0, 1'b1);
      check("glitch.after_tick", {2'b0, move_left}, 3'b000);

      // reset with a right request pending and start mid-debounce
      repeat (8) step(3'b010, 1'b0, 1'b1);
      repeat (3) step(3'b110, 1'b0, 1'b1);
      check("pre_clear.btn_level", btn_level, 3'b010);
      @(negedge CLK);
      clear = 1'b0;
      #1;
      check("clear_async.btn_level", btn_level, 3'b000);
      check("clear_async.pulses", {move_left, move_right, start_pulse}, 3'b000);
      model_reset();
      repeat (2) step(3'b110, 1'b0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         step(3'b110, 1'b0, 1'b1);
         check($sformatf("post_clear[%0d].start_pulse", k), {2'b0, start_pulse}, {2'b0, k == 7});
         check($sformatf("post_clear[%0d].move_right", k), {2'b0, move_right}, 3'b000);
         if (k == 6) check("post_clear.btn_level", btn_level, 3'b110);
      end
      step(3'b110, 1'b1, 1'b1);
      check("post_clear.new_press_tick", {2'b0, move_right}, 3'b001);
      repeat (6) step(3'b000, 1'b0, 1'b1);
      check("post_clear.released", btn_level, 3'b000);

      // held right with a tick every cycle
      for (int k = 1; k <= 50; k++) begin
         step(3'b010, 1'b1, 1'b1);
         exp_mr = (k == 8) || (REP && k >= 27 && ((k - 27) % RR) == 0);
         check($sformatf("hold_right[%0d].move_right", k), {2'b0, move_right}, {2'b0, exp_mr});
      end
      repeat (8) step(3'b000, 1'b1, 1'b1);

      // randomized run against the model
      b = 3'b000;
      for (int i = 0; i < 2500; i++) begin
         for (int c = 0; c < 3; c++)
            if ($urandom_range(0, 7) == 0) b[c] = ~b[c];
         step(b, $urandom_range(0, 3) == 0, $urandom_range(0, 299) != 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
